a5_1_keystream: RTL and testbench

- A5/1 keystream generator built around the three LFSRs (R1 19b, R2 22b, R3 23b).
- Drives the existing majority-clocking module: feeds it R1[8], R2[10] and R3[10], and consumes its R1/R2/R3 clock enables.
- Runs the full GSM sequence: key load, frame load, 100-step mix, then 228 keystream bits on a bit-serial valid/ready output.
- Sits between the session-key/frame-number register block and the burst XOR stage.

---
 rtl/a5_1_keystream.sv | 210 +++++++++++++++++++++
 tb/tb_a5_1_keystream.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/a5_1_keystream.sv
// A5/1 keystream generator: 64-bit key and 22-bit frame load, 100 mixing steps, then 228 bits.
// First ks_valid 187 cycles after start; while ks_valid & !ks_ready the bit and all LFSR state hold.

module a5_1_majority (
  input  logic i_c1,
  input  logic i_c2,
  input  logic i_c3,
  output logic o_en1,
  output logic o_en2,
  output logic o_en3
);
  logic w_maj;

  assign w_maj = (i_c1 & i_c2) | (i_c1 & i_c3) | (i_c2 & i_c3);
  assign o_en1 = (i_c1 == w_maj);
  assign o_en2 = (i_c2 == w_maj);
  assign o_en3 = (i_c3 == w_maj);
endmodule

module a5_1_keystream #(
  parameter int KS_BITS   = 228,
  parameter int MIX_STEPS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [21:0] frame,
  output logic        ks_bit,
  output logic        ks_valid,
  input  logic        ks_ready,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {S_IDLE, S_KEY, S_FRAME, S_MIX, S_GEN} state_t;

  localparam logic [7:0] LP_KEY_LAST = 8'd63;
  localparam logic [7:0] LP_FRM_LAST = 8'd21;
  localparam logic [7:0] LP_MIX_LAST = 8'(MIX_STEPS - 1);
  localparam logic [7:0] LP_KS_LAST  = 8'(KS_BITS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [63:0] r_key;
  logic [21:0] r_frame;
  logic [18:0] r_r1;
  logic [21:0] r_r2;
  logic [22:0] r_r3;
  logic        r_ks_bit;
  logic        r_ks_valid;
  logic        r_done;

  logic        w_step_all;
  logic        w_step_maj;
  logic        w_in_bit;
  logic        w_clr;
  logic        w_latch;
  logic        w_load_bit;
  logic        w_valid_nxt;
  logic        w_done_nxt;
  logic        w_maj_en1;
  logic        w_maj_en2;
  logic        w_maj_en3;
  logic        w_en1;
  logic        w_en2;
  logic        w_en3;
  logic [31:0] w_frame_pad;
  logic [18:0] w_r1_shift;
  logic [21:0] w_r2_shift;
  logic [22:0] w_r3_shift;
  logic [18:0] w_r1_nxt;
  logic [21:0] w_r2_nxt;
  logic [22:0] w_r3_nxt;
  logic        w_out_nxt;

  a5_1_majority u_majority (
    .i_c1  (r_r1[8]),
    .i_c2  (r_r2[10]),
    .i_c3  (r_r3[10]),
    .o_en1 (w_maj_en1),
    .o_en2 (w_maj_en2),
    .o_en3 (w_maj_en3)
  );

  assign w_frame_pad = {10'd0, r_frame};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_all  = 1'b0;
    w_step_maj  = 1'b0;
    w_in_bit    = 1'b0;
    w_clr       = 1'b0;
    w_latch     = 1'b0;
    w_load_bit  = 1'b0;
    w_valid_nxt = r_ks_valid;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_latch     = 1'b1;
          w_clr       = 1'b1;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_KEY;
        end
      end
      S_KEY: begin
        w_step_all = 1'b1;
        w_in_bit   = r_key[r_cnt[5:0]];
        if (r_cnt == LP_KEY_LAST) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_FRAME;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_FRAME: begin
        w_step_all = 1'b1;
        w_in_bit   = w_frame_pad[r_cnt[4:0]];
        if (r_cnt == LP_FRM_LAST) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_MIX;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_MIX: begin
        w_step_maj = 1'b1;
        if (r_cnt == LP_MIX_LAST) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_GEN;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_GEN: begin
        // r_cnt counts accepted bits; an empty output slot always triggers the next step
        if (!r_ks_valid) begin
          w_step_maj  = 1'b1;
          w_load_bit  = 1'b1;
          w_valid_nxt = 1'b1;
        end else if (ks_ready) begin
          if (r_cnt == LP_KS_LAST) begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_cnt_nxt   = 8'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_step_maj = 1'b1;
            w_load_bit = 1'b1;
            w_cnt_nxt  = r_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_cnt_nxt   = 8'd0;
        w_valid_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_en1 = w_step_all | (w_step_maj & w_maj_en1);
  assign w_en2 = w_step_all | (w_step_maj & w_maj_en2);
  assign w_en3 = w_step_all | (w_step_maj & w_maj_en3);

  assign w_r1_shift = {r_r1[17:0], r_r1[13] ^ r_r1[16] ^ r_r1[17] ^ r_r1[18] ^ w_in_bit};
  assign w_r2_shift = {r_r2[20:0], r_r2[20] ^ r_r2[21] ^ w_in_bit};
  assign w_r3_shift = {r_r3[21:0], r_r3[7] ^ r_r3[20] ^ r_r3[21] ^ r_r3[22] ^ w_in_bit};

  assign w_r1_nxt = w_clr ? '0 : (w_en1 ? w_r1_shift : r_r1);
  assign w_r2_nxt = w_clr ? '0 : (w_en2 ? w_r2_shift : r_r2);
  assign w_r3_nxt = w_clr ? '0 : (w_en3 ? w_r3_shift : r_r3);

  // keystream bit is taken from the post-step state
  assign w_out_nxt = w_r1_nxt[18] ^ w_r2_nxt[21] ^ w_r3_nxt[22];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_key      <= 64'd0;
      r_frame    <= 22'd0;
      r_r1       <= 19'd0;
      r_r2       <= 22'd0;
      r_r3       <= 23'd0;
      r_ks_bit   <= 1'b0;
      r_ks_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_key      <= w_latch ? key : r_key;
      r_frame    <= w_latch ? frame : r_frame;
      r_r1       <= w_r1_nxt;
      r_r2       <= w_r2_nxt;
      r_r3       <= w_r3_nxt;
      r_ks_bit   <= w_load_bit ? w_out_nxt : r_ks_bit;
      r_ks_valid <= w_valid_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign ks_bit   = r_ks_bit;
  assign ks_valid = r_ks_valid;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
endmodule

// File: tb/tb_a5_1_keystream.sv
// Bench for a5_1_keystream: published GSM test vector through a bit scoreboard,
// with backpressure, ignored start, mid-stream reset and back-to-back runs.

module tb_a5_1_keystream;
  localparam logic [63:0] KEY_STD = 64'hEFCDAB8967452312;
  localparam logic [21:0] FRM_STD = 22'h000134;
  localparam logic [63:0] KEY_ALT = 64'h0123456789ABCDEF;
  localparam logic [21:0] FRM_ALT = 22'h2AAAAA;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] key;
  logic [21:0] frame;
  logic        ks_bit;
  logic        ks_valid;
  logic        ks_ready;
  logic        busy;
  logic        done;

  int   n_vec    = 0;
  int   n_err    = 0;
  int   n_acc    = 0;
  int   n_done   = 0;
  int   exp_done = 0;
  bit   mon_en   = 1'b0;
  bit   rand_rdy = 1'b0;
  logic sb[$];

  a5_1_keystream dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .frame    (frame),
    .ks_bit   (ks_bit),
    .ks_valid (ks_valid),
    .ks_ready (ks_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // bits 0..113 and 114..227 of the reference vector, MSB-first
  function automatic logic exp_bit(input int i);
    logic [119:0] a;
    logic [119:0] b;
    a = 120'h534EAA582FE8151AB6E1855A728C00;
    b = 120'h24FD35A35D5FB6526D32F906DF1AC0;
    if (i < 114) return a[119-i];
    return b[119-(i-114)];
  endfunction

  task automatic push_std();
    for (int i = 0; i < 228; i++) sb.push_back(exp_bit(i));
  endtask

  initial begin
    ks_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ks_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // every valid sample must show the scoreboard head, so stalled bits must hold
  always @(negedge clk) begin
    if (mon_en && ks_valid) begin
      if (sb.size() == 0) begin
        chk("extra_bit", {31'd0, ks_valid}, 32'd0);
      end else begin
        chk("ks_bit", {31'd0, ks_bit}, {31'd0, sb[0]});
        if (ks_ready) begin
          void'(sb.pop_front());
          n_acc++;
        end
      end
    end
    if (mon_en && done) n_done++;
  end

  task automatic launch();
    push_std();
    @(posedge clk);
    #1;
    key   = KEY_STD;
    frame = FRM_STD;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_seq(input bit measure, input bit inj, input bit b2b);
    int lat = -1;
    int nb  = 0;
    bit got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (lat < 0 && ks_valid) lat = i;
      if (inj && i == 120) begin
        key   = KEY_ALT;
        frame = FRM_ALT;
        start = 1'b1;
      end
      if (inj && i == 121) start = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    exp_done++;
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("sb_drained", sb.size(), 32'd0);
    if (measure) begin
      chk("first_valid_latency", lat, 32'd187);
      // busy spans the 187-cycle lead-in plus the 228 output cycles
      chk("busy_cycles", nb, 32'd415);
    end
    if (b2b) begin
      key   = KEY_STD;
      frame = FRM_STD;
      start = 1'b1;
      push_std();
    end else begin
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int base;
    rst   = 1'b1;
    start = 1'b0;
    key   = 64'd0;
    frame = 22'd0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    repeat (5) @(negedge clk);
    chk("rst_valid", {31'd0, ks_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_r1", {13'd0, dut.r_r1}, 32'd0);
    chk("rst_r2", {10'd0, dut.r_r2}, 32'd0);
    chk("rst_r3", {9'd0, dut.r_r3}, 32'd0);

    launch();
    wait_seq(1'b1, 1'b0, 1'b0);

    rand_rdy = 1'b1;
    launch();
    wait_seq(1'b0, 1'b0, 1'b0);
    rand_rdy = 1'b0;

    launch();
    wait_seq(1'b0, 1'b1, 1'b0);

    launch();
    base = n_acc;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (n_acc >= base + 50) break;
    end
    #1;
    chk("reach_bit50", n_acc - base, 32'd50);
    rst    = 1'b1;
    mon_en = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", {31'd0, ks_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    launch();
    wait_seq(1'b1, 1'b0, 1'b0);

    launch();
    wait_seq(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_seq(1'b1, 1'b0, 1'b0);

    chk("done_pulses", n_done, exp_done);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
